// File: rtl/otter_fetch_queue.sv
// Instruction fetch stage for the pipelined OTTER: owns the fetch PC, issues in-order
// word requests to instruction memory and buffers returned words with their PCs for decode.
module otter_fetch_queue #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUT   = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        ID_VALID,
    output logic [31:0] ID_IR,
    output logic [31:0] ID_PC,
    input  logic        ID_READY
);

    localparam int QW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int RW = CW + OW + 1;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] disc_q, disc_d;
    logic [QW-1:0] head_q, head_d;
    logic [QW-1:0] tail_q, tail_d;
    logic [31:0]   ir_q  [DEPTH];
    logic [31:0]   ir_d  [DEPTH];
    logic [31:0]   qpc_q [DEPTH];
    logic [31:0]   qpc_d [DEPTH];
    logic [31:0]   ppc_q [MAX_OUT];
    logic [31:0]   ppc_d [MAX_OUT];
    logic [PW-1:0] pwr_q, pwr_d;
    logic [PW-1:0] prd_q, prd_d;

    logic [RW-1:0] resv_s;
    logic          req_s;
    logic          gnt_s;
    logic          rsp_s;
    logic          valid_s;
    logic          deq_s;
    logic          enq_s;
    logic          drop_s;
    logic          unused_rpc_s;

    // Pending-PC FIFO pointer advance; MAX_OUT need not be a power of two.
    function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(MAX_OUT - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + 1'b1;
        end
        return r;
    endfunction

    assign unused_rpc_s = ^REDIRECT_PC[1:0];

    // Request gating and handshake qualifiers; queue space is reserved per in-flight word
    // not destined for the discard path.
    always_comb begin
        resv_s  = RW'(cnt_q) + RW'(out_q) - RW'(disc_q);
        req_s   = RESET_N && !REDIRECT && (out_q < OW'(MAX_OUT)) && (resv_s < RW'(DEPTH));
        gnt_s   = req_s && IMEM_GNT;
        rsp_s   = IMEM_RVALID && (out_q != {OW{1'b0}});
        valid_s = (cnt_q != {CW{1'b0}});
        deq_s   = valid_s && ID_READY && !REDIRECT;
        enq_s   = rsp_s && !REDIRECT && (disc_q == {OW{1'b0}});
        drop_s  = rsp_s && !REDIRECT && (disc_q != {OW{1'b0}});
    end

    // Next-state for fetch PC, counters, pending FIFO and instruction queue.
    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        disc_d = disc_q;
        head_d = head_q;
        tail_d = tail_q;
        ir_d   = ir_q;
        qpc_d  = qpc_q;
        ppc_d  = ppc_q;
        pwr_d  = pwr_q;
        prd_d  = prd_q;
        out_d  = out_q + OW'(gnt_s) - OW'(rsp_s);

        if (gnt_s) begin
            ppc_d[pwr_q] = pc_q;
            pwr_d        = pinc(pwr_q);
            pc_d         = pc_q + 32'd4;
        end else begin
            pwr_d = pwr_q;
        end

        if (rsp_s) begin
            prd_d = pinc(prd_q);
        end else begin
            prd_d = prd_q;
        end

        if (REDIRECT) begin
            pc_d   = {REDIRECT_PC[31:2], 2'b00};
            cnt_d  = {CW{1'b0}};
            tail_d = head_q;
            disc_d = out_q - OW'(rsp_s);
        end else begin
            if (enq_s) begin
                ir_d[tail_q]  = IMEM_RDATA;
                qpc_d[tail_q] = ppc_q[prd_q];
                tail_d        = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (drop_s) begin
                disc_d = disc_q - 1'b1;
            end else begin
                disc_d = disc_q;
            end
            if (deq_s) begin
                head_d = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            cnt_d = cnt_q + CW'(enq_s) - CW'(deq_s);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q   <= RESET_VEC;
            cnt_q  <= {CW{1'b0}};
            out_q  <= {OW{1'b0}};
            disc_q <= {OW{1'b0}};
            head_q <= {QW{1'b0}};
            tail_q <= {QW{1'b0}};
            pwr_q  <= {PW{1'b0}};
            prd_q  <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ir_q[i]  <= 32'h0000_0000;
                qpc_q[i] <= 32'h0000_0000;
            end
            for (int j = 0; j < MAX_OUT; j++) begin
                ppc_q[j] <= 32'h0000_0000;
            end
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            pwr_q  <= pwr_d;
            prd_q  <= prd_d;
            ir_q   <= ir_d;
            qpc_q  <= qpc_d;
            ppc_q  <= ppc_d;
        end
    end

    assign IMEM_REQ  = req_s;
    assign IMEM_ADDR = pc_q;
    assign ID_VALID  = valid_s;
    assign ID_IR     = valid_s ? ir_q[head_q]  : NOP_IR;
    assign ID_PC     = valid_s ? qpc_q[head_q] : 32'h0000_0000;

endmodule

// File: doc/otter_fetch_queue.md
# otter_fetch_queue

Instruction fetch stage for the pipelined OTTER. It owns the fetch PC and issues in-order word requests to instruction memory over a request/grant/response handshake, tolerating variable memory latency. Returned words are buffered with their PCs in a small queue that feeds decode through a valid/ready handshake. Redirects from execute (taken branch, jump, trap) flush the queue and squash in-flight responses.

## Interface
- RESET_VEC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 4, queue entries; power of two, 2..8
- MAX_OUT, 2, max in-flight memory requests, 1..3
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REDIRECT  in  1  flush and restart fetch at REDIRECT_PC
- REDIRECT_PC  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- IMEM_REQ  out  1  request valid
- IMEM_ADDR  out  32  word-aligned request address (the fetch PC)
- IMEM_GNT  in  1  request accepted this cycle; meaningful only while IMEM_REQ=1
- IMEM_RVALID  in  1  response valid; responses return in order, at least 1 cycle after grant
- IMEM_RDATA  in  32  instruction word
- ID_VALID  out  1  queue head valid
- ID_IR  out  32  head instruction; 32'h0000_0013 (NOP) when ID_VALID=0
- ID_PC  out  32  head PC; 0 when ID_VALID=0
- ID_READY  in  1  decode accepts head; low during load-use stall

## Operation
- State: fetch PC, circular queue of {IR, PC} with count C, outstanding counter O, discard counter D (D ≤ O), and a pending-PC FIFO of MAX_OUT entries recording the PC of each granted request.
- IMEM_REQ = !REDIRECT && O < MAX_OUT && (C + O − D) < DEPTH. Space is reserved at request time, so responses never overflow the queue.
- Grant (IMEM_REQ && IMEM_GNT): push PC into the pending FIFO, PC += 4, O += 1.
- Response (IMEM_RVALID): O −= 1 and pop the pending FIFO. If D > 0, drop the word and decrement D; otherwise enqueue {IMEM_RDATA, popped PC}.
- Dequeue when ID_VALID && ID_READY. Enqueue and dequeue in the same cycle leave C unchanged.
- Redirect has priority over everything:
  - C ← 0 and PC ← {REDIRECT_PC[31:2], 2'b00}.
  - D ← O − IMEM_RVALID; any response arriving in the redirect cycle is dropped.
  - IMEM_REQ is low in the redirect cycle, so no grant can coincide with a redirect.
  - Dequeue in that cycle is ignored.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. The queue pointers wrap modulo DEPTH.
- A response with O = 0 is a protocol error: ignore it and hold all counters.

## Timing
- Reset (asynchronous, immediate): PC=RESET_VEC, C=O=D=0, IMEM_REQ=0, IMEM_ADDR=RESET_VEC, ID_VALID=0, ID_IR=32'h0000_0013, ID_PC=0.
- IMEM_REQ rises combinationally in the first cycle after RESET_N deasserts.
- The queue has no bypass. A word returned in cycle t appears on ID_* in cycle t+1.
- With 1-cycle memory and ID_READY=1, throughput is 1 instruction/cycle. First ID_VALID comes 2 cycles after the first grant.
- While IMEM_REQ=1 and IMEM_GNT=0, IMEM_ADDR is held stable. It changes only after a grant or in the cycle after a redirect.
- ID_IR and ID_PC hold stable while ID_VALID=1 and ID_READY=0.
- Redirect in cycle t:
  - ID_VALID=0 in cycle t+1.
  - IMEM_REQ=1 with IMEM_ADDR=REDIRECT_PC in t+1.
  - The first redirected instruction reaches decode no earlier than t+3 with 1-cycle memory.
- Back-to-back redirects are legal. The second overrides the first, and D is recomputed from the current O.
- RESET_N asserted mid-operation: in-flight responses are forgotten. Instruction memory shares RESET_N and returns nothing for pre-reset grants.

## Test plan
- Reset release, 1-cycle memory, ID_READY=1, RESET_VEC=0 -> ID_PC sequence 0,4,8,C… one per cycle from cycle 3; ID_IR matches memory contents.
- ID_READY low for 10 cycles from steady state -> C reaches 4, then IMEM_REQ=0 with O=0. On release, 4 consecutive instructions arrive in order with no gaps or duplicates.
- 3-cycle memory latency, 2 outstanding, REDIRECT to 0x100 -> both stale responses dropped (D goes 2→0); next ID_VALID shows ID_PC=0x100.
- Redirect with a response landing in the same cycle, to 0x203 -> that response dropped; fetch restarts at 0x200.
- IMEM_GNT held 0 for 5 cycles -> IMEM_REQ=1 and IMEM_ADDR constant throughout; PC advances by exactly 4 after the grant.
- RESET_N pulsed low mid-stream with queue half full -> outputs take reset values in the same cycle; after release, fetch restarts at RESET_VEC.
